sd_spi_ctrl: RTL and testbench
==============================

Name: sd_spi_ctrl

Overview:
- Byte-wide SPI master (mode 0, MSB first) that replaces bit-banged GPIO control of the SD card pins.
- Sits behind the Z8S180 IO decoder. The top level presents one-phi-cycle read/write strobes (derived from the synchronised IO tick) for a 4-byte port window at 0xF4-0xF7.
- Generates sd_clk, sd_mosi and sd_ssel_n, samples sd_miso, and exposes status to the CPU.

Parameters:
- DIV_W, 8, width of the SCK half-period divisor register.
- DIV_RESET, 8'd24, divisor after reset. Half-period = (div+1) phi cycles, giving an init-speed SCK of ≤400 kHz.

Ports:
- phi  input  1  system clock, all logic on posedge
- reset  input  1  asynchronous, active-high
- io_wr  input  1  one-cycle write strobe for this port window
- io_rd  input  1  one-cycle read strobe for this port window
- io_addr  input  2  register select: 0 data, 1 ctrl/status, 2 divisor, 3 reserved
- io_wdata  input  8  CPU write data
- io_rdata  output  8  combinational read data for the selected register
- sd_miso  input  1  card data out
- sd_det  input  1  card-detect switch
- sd_mosi  output  1  card data in
- sd_clk  output  1  SPI clock
- sd_ssel_n  output  1  card select, active low
- busy  output  1  transfer in progress

Behaviour:
- Clock and reset: one clock (phi); reset is asynchronous and active-high.
- Reset values: sd_clk=0, sd_mosi=1, sd_ssel_n=1, busy=0, state=IDLE, rx_data=8'hFF, div=DIV_RESET, overrun=0.
- Register map:
  - Read 0: rx_data.
  - Read 1: {sd_miso, sd_det, 3'b0, overrun, ~sd_ssel_n, busy}.
  - Read 2: div.
  - Read 3: 8'h00.
  - Write 1: bit0 → sd_ssel_n = ~bit0, applied next cycle even if busy; bit2=1 clears overrun.
  - Write 2: loads div_next; copied into the working divisor at the start of each byte.
  - Write 3: ignored.
- FSM states: IDLE, LOW, HIGH.
- IDLE + write to reg 0:
  - load tx shift register = io_wdata, sd_mosi = io_wdata[7], bit_cnt=7, div_cnt=div_next;
  - go to LOW; busy=1 from the next edge.
- LOW: decrement div_cnt. At 0: sd_clk←1, sample sd_miso into the rx shift LSB, reload div_cnt, go to HIGH.
- HIGH: decrement div_cnt. At 0: sd_clk←0. Then:
  - if bit_cnt==0: rx_data←assembled byte, sd_mosi←1, busy←0, go to IDLE;
  - else: shift, sd_mosi←next bit, bit_cnt−1, reload, go to LOW.
- Transfer length: exactly 16*(div+1) phi cycles from the first busy=1 edge to busy=0. rx_data updates on the same edge busy falls.
- Write to reg 0 while busy: data discarded, overrun←1 (sticky), transfer unaffected.
- rd and wr strobes in the same cycle: the write takes effect; io_rdata shows the pre-write value.
- div=0: SCK = phi/2, which is the legal minimum.
- Reset mid-transfer: immediate abort to reset values. No partial rx_data update.

Optional Feature:
- Macro: SD_SPI_AUTOREAD_EN.
- When defined: a read of reg 0 while IDLE returns the current rx_data and starts a transfer of 8'hFF. This allows block reads with one IO read per byte. A read of reg 0 while busy returns rx_data and starts nothing. A simultaneous write to reg 0 takes precedence over the auto transfer.
- When undefined: reads never start transfers.

Decomposition:
- Package sd_spi_pkg holds:
  - register offsets (REG_DATA=0, REG_CTRL=1, REG_DIV=2);
  - state encoding (IDLE/LOW/HIGH);
  - status bit indices (ST_BUSY=0, ST_SEL=1, ST_OVR=2, ST_DET=6, ST_MISO=7).
- One natural sub-module, sd_spi_baud: a loadable down-counter producing a half-period tick from div. The FSM and shift registers stay in sd_spi_ctrl.

Test Plan:
- Reset default, write 0x00 to reg0 with miso=1 → SCK period 50 phi cycles, busy high 400 cycles, reg0 reads 0xFF.
- Write div=0, then write 0xA5 with miso tied 0 → mosi at the 8 rising edges = 1,0,1,0,0,1,0,1; busy 16 cycles; reg0=0x00.
- Loop mosi→miso, div=1, write 0x3C → reg0=0x3C after 32 cycles; sd_clk idles 0; sd_mosi idles 1.
- Write 0x55 then 0xAA mid-transfer → reg1 bit2=1, wire bit sequence is 0x55 only; write reg1=0x04 → bit2 clears.
- Write reg1=0x01 → sd_ssel_n=0; assert reset at bit 3 of a transfer → sd_clk=0, sd_ssel_n=1, busy=0, reg0=0xFF, reg2=24.
- With SD_SPI_AUTOREAD_EN, miso pattern 0x81, read reg0 twice with a wait between → second read returns 0x81; mosi stays 1 for all 8 bits.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared definitions for the SD-card SPI master.
//   - register offsets inside the 4-byte IO window (0xF4-0xF7)
//   - FSM state encoding (IDLE / LOW / HIGH)
//   - bit positions of the ctrl/status byte, plus a helper that packs it
package sd_spi_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_CTRL = 2'd1;
  localparam logic [1:0] REG_DIV  = 2'd2;
  localparam logic [1:0] REG_RSVD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } spi_state_e;

  localparam int ST_BUSY = 0;
  localparam int ST_SEL  = 1;
  localparam int ST_OVR  = 2;
  localparam int ST_DET  = 6;
  localparam int ST_MISO = 7;

  // Packs the ctrl/status read byte; unused bits read as zero.
  function automatic logic [7:0] status_byte(input logic miso, input logic det,
                                             input logic ovr, input logic sel,
                                             input logic bsy);
    logic [7:0] s;
    s          = 8'h00;
    s[ST_MISO] = miso;
    s[ST_DET]  = det;
    s[ST_OVR]  = ovr;
    s[ST_SEL]  = sel;
    s[ST_BUSY] = bsy;
    return s;
  endfunction

endpackage

// File: rtl/sd_spi_ctrl_baud.sv
// sd_spi_ctrl_baud (module sd_spi_baud): half-period tick generator.
//   load    : capture div_in as the working divisor and preload the counter
//   en      : count while a transfer is running
//   tick    : high for the last phi cycle of each half-period of (div+1) cycles;
//             the counter reloads from the working divisor on that cycle
module sd_spi_baud #(
  parameter int DIV_W = 8
) (
  input  logic             phi,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] div_in,
  input  logic             en,
  output logic             tick
);

  localparam logic [DIV_W-1:0] CNT_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] cnt_r;

  assign tick = en && (cnt_r == CNT_ZERO);

  // Working divisor latch and half-period down-counter.
  always_ff @(posedge phi or posedge reset) begin
    if (reset) begin
      div_r <= CNT_ZERO;
      cnt_r <= CNT_ZERO;
    end else if (load) begin
      div_r <= div_in;
      cnt_r <= div_in;
    end else if (en) begin
      if (cnt_r == CNT_ZERO) begin
        cnt_r <= div_r;
      end else begin
        cnt_r <= cnt_r - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/sd_spi_ctrl.sv
// sd_spi_ctrl: byte-wide SPI master (mode 0, MSB first) for the SD card slot.
// Ports:
//   phi, reset            clock (posedge) and asynchronous active-high reset
//   io_wr, io_rd          one-cycle strobes for the 0xF4-0xF7 window
//   io_addr, io_wdata     register select / write data
//   io_rdata              combinational read data of the selected register
//   sd_miso, sd_det       card data out, card-detect switch
//   sd_mosi, sd_clk       card data in, SPI clock (idles 0, mosi idles 1)
//   sd_ssel_n, busy       card select (active low), transfer in progress
// Optional feature (macro SD_SPI_AUTOREAD_EN): an idle read of the data
// register returns rx_data and launches an 8'hFF transfer for block reads.
module sd_spi_ctrl
  import sd_spi_pkg::*;
#(
  parameter int               DIV_W     = 8,
  parameter logic [DIV_W-1:0] DIV_RESET = 8'd24
) (
  input  logic       phi,
  input  logic       reset,
  input  logic       io_wr,
  input  logic       io_rd,
  input  logic [1:0] io_addr,
  input  logic [7:0] io_wdata,
  output logic [7:0] io_rdata,
  input  logic       sd_miso,
  input  logic       sd_det,
  output logic       sd_mosi,
  output logic       sd_clk,
  output logic       sd_ssel_n,
  output logic       busy
);

  spi_state_e       state_r, state_next_s;
  logic             tick_s, start_s, rise_s, fall_s, done_s;
  logic             wr_data_s, auto_s;
  logic [7:0]       tx_load_s;
  logic [6:0]       tx_rest_r;    // bits still to send after the one on sd_mosi
  logic [7:0]       rx_sh_r;
  logic [7:0]       rx_data_r;
  logic [2:0]       bit_cnt_r;
  logic [DIV_W-1:0] div_next_r;
  logic             overrun_r, ssel_n_r, sd_clk_r, sd_mosi_r, busy_r;

  assign sd_clk    = sd_clk_r;
  assign sd_mosi   = sd_mosi_r;
  assign sd_ssel_n = ssel_n_r;
  assign busy      = busy_r;
  assign wr_data_s = io_wr && (io_addr == REG_DATA);

`ifdef SD_SPI_AUTOREAD_EN
  // A simultaneous data write wins over the auto-read launch.
  assign auto_s = io_rd && (io_addr == REG_DATA) && !wr_data_s;
`else
  logic unused_rd_s;
  assign unused_rd_s = io_rd;
  assign auto_s      = 1'b0;
`endif

  sd_spi_baud #(.DIV_W(DIV_W)) u_baud (
    .phi    (phi),
    .reset  (reset),
    .load   (start_s),
    .div_in (div_next_r),
    .en     (state_r != IDLE),
    .tick   (tick_s)
  );

  // FSM state register.
  always_ff @(posedge phi or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic and the per-edge datapath controls.
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    rise_s       = 1'b0;
    fall_s       = 1'b0;
    done_s       = 1'b0;
    tx_load_s    = io_wdata;
    case (state_r)
      IDLE: begin
        if (wr_data_s) begin
          start_s      = 1'b1;
          state_next_s = LOW;
        end else if (auto_s) begin
          start_s      = 1'b1;
          tx_load_s    = 8'hFF;
          state_next_s = LOW;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOW: begin
        if (tick_s) begin
          rise_s       = 1'b1;
          state_next_s = HIGH;
        end else begin
          state_next_s = LOW;
        end
      end
      HIGH: begin
        if (tick_s) begin
          fall_s = 1'b1;
          if (bit_cnt_r == 3'd0) begin
            done_s       = 1'b1;
            state_next_s = IDLE;
          end else begin
            state_next_s = LOW;
          end
        end else begin
          state_next_s = HIGH;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Shift registers, SPI pins and busy flag.
  always_ff @(posedge phi or posedge reset) begin
    if (reset) begin
      tx_rest_r <= 7'h7F;
      rx_sh_r   <= 8'hFF;
      rx_data_r <= 8'hFF;
      bit_cnt_r <= 3'd0;
      sd_clk_r  <= 1'b0;
      sd_mosi_r <= 1'b1;
      busy_r    <= 1'b0;
    end else if (start_s) begin
      tx_rest_r <= tx_load_s[6:0];
      sd_mosi_r <= tx_load_s[7];
      bit_cnt_r <= 3'd7;
      busy_r    <= 1'b1;
    end else if (rise_s) begin
      sd_clk_r <= 1'b1;
      rx_sh_r  <= {rx_sh_r[6:0], sd_miso};
    end else if (fall_s) begin
      sd_clk_r <= 1'b0;
      if (done_s) begin
        rx_data_r <= rx_sh_r;
        sd_mosi_r <= 1'b1;
        busy_r    <= 1'b0;
      end else begin
        sd_mosi_r <= tx_rest_r[6];
        tx_rest_r <= {tx_rest_r[5:0], 1'b1};
        bit_cnt_r <= bit_cnt_r - 3'd1;
      end
    end
  end

  // CPU-visible control registers: select, divisor, sticky overrun.
  always_ff @(posedge phi or posedge reset) begin
    if (reset) begin
      ssel_n_r   <= 1'b1;
      div_next_r <= DIV_RESET;
      overrun_r  <= 1'b0;
    end else if (io_wr) begin
      case (io_addr)
        REG_DATA: if (state_r != IDLE) overrun_r <= 1'b1;
        REG_CTRL: begin
          ssel_n_r <= ~io_wdata[0];
          if (io_wdata[2]) overrun_r <= 1'b0;
        end
        REG_DIV:  div_next_r <= DIV_W'(io_wdata);
        default:  ;
      endcase
    end
  end

  // Read mux; shows register contents from before any same-cycle write.
  always_comb begin
    io_rdata = 8'h00;
    case (io_addr)
      REG_DATA: io_rdata = rx_data_r;
      REG_CTRL: io_rdata = status_byte(sd_miso, sd_det, overrun_r, ~ssel_n_r, busy_r);
      REG_DIV:  io_rdata = 8'(div_next_r);
      default:  io_rdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_sd_spi_ctrl.sv
// tb_sd_spi_ctrl: self-checking bench for sd_spi_ctrl. A behavioural card
// model drives sd_miso (constant, loopback or byte pattern); expected bytes,
// bit sequences and timing come from the SPI rules: 8 bits MSB first,
// half-period div+1 phi cycles, 16*(div+1) busy cycles.
module tb_sd_spi_ctrl;

  logic       phi = 1'b0;
  logic       reset = 1'b1;
  logic       io_wr = 1'b0;
  logic       io_rd = 1'b0;
  logic [1:0] io_addr = 2'd0;
  logic [7:0] io_wdata = 8'h00;
  logic [7:0] io_rdata;
  logic       sd_miso = 1'b1;
  logic       sd_det = 1'b0;
  logic       sd_mosi, sd_clk, sd_ssel_n, busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Results collected by run_xfer
  int         r_busy, r_rises, r_first, r_period;
  logic [7:0] r_bits;
  logic       r_clk_end, r_mosi_end;

  sd_spi_ctrl dut (
    .phi(phi), .reset(reset), .io_wr(io_wr), .io_rd(io_rd), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .sd_miso(sd_miso), .sd_det(sd_det),
    .sd_mosi(sd_mosi), .sd_clk(sd_clk), .sd_ssel_n(sd_ssel_n), .busy(busy)
  );

  always #5 phi = ~phi;

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge phi);
    io_wr = 1'b1; io_addr = a; io_wdata = d;
    @(negedge phi);
    io_wr = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    @(negedge phi);
    io_addr = a;
    #1 d = io_rdata;
  endtask

  function automatic logic card_bit(input int mode, input logic [7:0] pat, input int k);
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return sd_mosi;
      default: return (k < 8) ? pat[7-k] : 1'b1;
    endcase
  endfunction

  function automatic logic [7:0] exp_rx(input int mode, input logic [7:0] tx, input logic [7:0] pat);
    case (mode)
      0: return 8'h00;
      1: return 8'hFF;
      2: return tx;
      default: return pat;
    endcase
  endfunction

  // Starts one transfer (write, or strobed read when by_read) and monitors it
  // until busy drops or a cycle budget runs out. inject_at >= 0 writes 0xAA
  // to the data register at that busy cycle.
  task automatic run_xfer(input logic [7:0] tx, input logic by_read, input int mode,
                          input logic [7:0] pat, input int inject_at);
    logic prev;
    @(negedge phi);
    io_addr = 2'd0;
    if (by_read) io_rd = 1'b1;
    else begin io_wr = 1'b1; io_wdata = tx; end
    sd_miso = card_bit(mode, pat, 0);
    @(negedge phi);
    io_wr = 1'b0; io_rd = 1'b0;
    r_busy = 0; r_rises = 0; r_bits = 8'h00; r_first = -1; r_period = -1; prev = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if (busy !== 1'b1) break;
      r_busy++;
      if (sd_clk === 1'b1 && prev === 1'b0) begin
        if (r_rises < 8) r_bits[7-r_rises] = sd_mosi;
        if (r_rises == 0) r_first = c;
        else if (r_rises == 1) r_period = c - r_first;
        r_rises++;
      end
      prev = sd_clk;
      sd_miso = card_bit(mode, pat, r_rises);
      io_wr = 1'b0;
      if (c == inject_at) begin io_wr = 1'b1; io_addr = 2'd0; io_wdata = 8'hAA; end
      @(negedge phi);
    end
    io_wr = 1'b0;
    r_clk_end = sd_clk;
    r_mosi_end = sd_mosi;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    sd_det = 1'b1; sd_miso = 1'b1;
    peek(2'd0, d);
    total_cnt++; if (d !== 8'hFF) $display("FAIL reset_rx got %h want ff", d); else pass_cnt++;
    peek(2'd1, d);
    total_cnt++; if (d !== 8'hC0) $display("FAIL reset_status got %h want c0", d); else pass_cnt++;
    peek(2'd2, d);
    total_cnt++; if (d !== 8'd24) $display("FAIL reset_div got %0d want 24", d); else pass_cnt++;
    peek(2'd3, d);
    total_cnt++; if (d !== 8'h00) $display("FAIL reset_rsvd got %h want 00", d); else pass_cnt++;
    total_cnt++;
    if ({sd_clk, sd_mosi, sd_ssel_n, busy} !== 4'b0110)
      $display("FAIL reset_pins got %b want 0110", {sd_clk, sd_mosi, sd_ssel_n, busy});
    else pass_cnt++;
  endtask

  task automatic test_default_div;
    logic [7:0] d;
    run_xfer(8'h00, 1'b0, 1, 8'h00, -1);
    total_cnt++; if (r_period !== 50) $display("FAIL def_period got %0d want 50", r_period); else pass_cnt++;
    total_cnt++; if (r_busy !== 400) $display("FAIL def_busy got %0d want 400", r_busy); else pass_cnt++;
    total_cnt++; if (r_first !== 25) $display("FAIL def_first_rise got %0d want 25", r_first); else pass_cnt++;
    peek(2'd0, d);
    total_cnt++; if (d !== 8'hFF) $display("FAIL def_rx got %h want ff", d); else pass_cnt++;
  endtask

  task automatic test_div0;
    logic [7:0] d;
    wr(2'd2, 8'd0);
    run_xfer(8'hA5, 1'b0, 0, 8'h00, -1);
    total_cnt++; if (r_bits !== 8'hA5) $display("FAIL div0_bits got %h want a5", r_bits); else pass_cnt++;
    total_cnt++; if (r_busy !== 16) $display("FAIL div0_busy got %0d want 16", r_busy); else pass_cnt++;
    total_cnt++; if (r_period !== 2) $display("FAIL div0_period got %0d want 2", r_period); else pass_cnt++;
    peek(2'd0, d);
    total_cnt++; if (d !== 8'h00) $display("FAIL div0_rx got %h want 00", d); else pass_cnt++;
  endtask

  task automatic test_loopback;
    logic [7:0] d;
    wr(2'd2, 8'd1);
    run_xfer(8'h3C, 1'b0, 2, 8'h00, -1);
    total_cnt++; if (r_busy !== 32) $display("FAIL loop_busy got %0d want 32", r_busy); else pass_cnt++;
    peek(2'd0, d);
    total_cnt++; if (d !== 8'h3C) $display("FAIL loop_rx got %h want 3c", d); else pass_cnt++;
    total_cnt++;
    if ({r_clk_end, r_mosi_end} !== 2'b01)
      $display("FAIL loop_idle got %b want 01", {r_clk_end, r_mosi_end});
    else pass_cnt++;
  endtask

  task automatic test_random;
    logic [7:0] tx, pat, d, dv;
    int mode;
    for (int i = 0; i < 8; i++) begin
      tx = 8'($urandom); pat = 8'($urandom);
      dv = 8'($urandom_range(0, 3)); mode = $urandom_range(0, 3);
      wr(2'd2, dv);
      run_xfer(tx, 1'b0, mode, pat, -1);
      total_cnt++;
      if (r_bits !== tx) $display("FAIL rnd_bits[%0d] got %h want %h", i, r_bits, tx); else pass_cnt++;
      total_cnt++;
      if (r_busy !== 16 * (int'(dv) + 1)) $display("FAIL rnd_busy[%0d] got %0d want %0d", i, r_busy, 16 * (int'(dv) + 1));
      else pass_cnt++;
      peek(2'd0, d);
      total_cnt++;
      if (d !== exp_rx(mode, tx, pat)) $display("FAIL rnd_rx[%0d] got %h want %h", i, d, exp_rx(mode, tx, pat));
      else pass_cnt++;
    end
  endtask

  task automatic test_overrun;
    logic [7:0] d;
    wr(2'd2, 8'd1);
    run_xfer(8'h55, 1'b0, 2, 8'h00, 9);
    total_cnt++; if (r_bits !== 8'h55) $display("FAIL ovr_bits got %h want 55", r_bits); else pass_cnt++;
    total_cnt++; if (r_busy !== 32) $display("FAIL ovr_busy got %0d want 32", r_busy); else pass_cnt++;
    peek(2'd1, d);
    total_cnt++; if (d[2] !== 1'b1) $display("FAIL ovr_set got %b want 1", d[2]); else pass_cnt++;
    peek(2'd0, d);
    total_cnt++; if (d !== 8'h55) $display("FAIL ovr_rx got %h want 55", d); else pass_cnt++;
    wr(2'd1, 8'h04);
    peek(2'd1, d);
    total_cnt++; if (d[2] !== 1'b0) $display("FAIL ovr_clear got %b want 0", d[2]); else pass_cnt++;
  endtask

  task automatic test_rd_wr_same;
    logic [7:0] d;
    @(negedge phi);
    io_addr = 2'd2; io_wr = 1'b1; io_rd = 1'b1; io_wdata = 8'h07;
    #1 d = io_rdata;
    total_cnt++; if (d !== 8'd1) $display("FAIL rdwr_old got %h want 01", d); else pass_cnt++;
    @(negedge phi);
    io_wr = 1'b0; io_rd = 1'b0;
    peek(2'd2, d);
    total_cnt++; if (d !== 8'h07) $display("FAIL rdwr_new got %h want 07", d); else pass_cnt++;
  endtask

  task automatic test_select_reset;
    logic [7:0] d;
    wr(2'd1, 8'h01);
    total_cnt++; if (sd_ssel_n !== 1'b0) $display("FAIL sel_on got %b want 0", sd_ssel_n); else pass_cnt++;
    peek(2'd1, d);
    total_cnt++; if (d[1] !== 1'b1) $display("FAIL sel_status got %b want 1", d[1]); else pass_cnt++;
    wr(2'd2, 8'd2);
    wr(2'd0, 8'h5A);
    repeat (20) @(negedge phi);
    total_cnt++; if (busy !== 1'b1) $display("FAIL abort_busy_before got %b want 1", busy); else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if ({sd_clk, sd_mosi, sd_ssel_n, busy} !== 4'b0110)
      $display("FAIL abort_pins got %b want 0110", {sd_clk, sd_mosi, sd_ssel_n, busy});
    else pass_cnt++;
    @(negedge phi);
    reset = 1'b0;
    peek(2'd0, d);
    total_cnt++; if (d !== 8'hFF) $display("FAIL abort_rx got %h want ff", d); else pass_cnt++;
    peek(2'd2, d);
    total_cnt++; if (d !== 8'd24) $display("FAIL abort_div got %0d want 24", d); else pass_cnt++;
  endtask

  task automatic test_read_strobe;
    logic [7:0] d;
    wr(2'd2, 8'd0);
`ifdef SD_SPI_AUTOREAD_EN
    run_xfer(8'hFF, 1'b1, 3, 8'h81, -1);
    total_cnt++; if (r_bits !== 8'hFF) $display("FAIL auto_bits got %h want ff", r_bits); else pass_cnt++;
    total_cnt++; if (r_busy !== 16) $display("FAIL auto_busy got %0d want 16", r_busy); else pass_cnt++;
    repeat (3) @(negedge phi);
    io_addr = 2'd0; io_rd = 1'b1;
    #1 d = io_rdata;
    total_cnt++; if (d !== 8'h81) $display("FAIL auto_rx got %h want 81", d); else pass_cnt++;
    @(negedge phi);
    io_rd = 1'b0;
    for (int c = 0; c < 40 && busy === 1'b1; c++) @(negedge phi);
    total_cnt++; if (busy !== 1'b0) $display("FAIL auto_end got %b want 0", busy); else pass_cnt++;
`else
    @(negedge phi);
    io_addr = 2'd0; io_rd = 1'b1;
    @(negedge phi);
    io_rd = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rd_nostart got %b want 0", busy); else pass_cnt++;
    peek(2'd0, d);
    total_cnt++; if (d !== 8'hFF) $display("FAIL rd_keep got %h want ff", d); else pass_cnt++;
`endif
  endtask

  initial begin
    repeat (3) @(negedge phi);
    reset = 1'b0;
    test_reset;
    test_default_div;
    test_div0;
    test_loopback;
    test_random;
    test_overrun;
    test_rd_wr_same;
    test_select_reset;
    test_read_strobe;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
